dm_access_arbiter: RTL and testbench

//  Sequences and shares the word-organised data memory between the CPU MEM stage and a DMA port.

---
 rtl/dm_access_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dm_access_arbiter                                             |
// | Brief    : Shares a word-wide data memory between CPU and DMA requesters,|
// |            with read-modify-write for partial byte-enable stores.        |
// | Options  : DM_ARB_ROUND_ROBIN_EN selects round-robin instead of          |
// |            fixed CPU priority on simultaneous requests.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dm_access_arbiter #(
    parameter int WORD_BITS = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [3:0]  dma_be,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        dm_we,
    output logic [31:0] dm_waddr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_raddr,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

    state_t      state_q, state_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        id_q;
    logic [31:0] cpu_rdata_q, dma_rdata_q;
    logic        cpu_err_q, dma_err_q;

    logic        grant_dma;
    logic        any_req;
    logic        addr_err;
    logic        partial;
    logic        finish;
    logic [31:0] byte_mask;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        we_c;
    logic [31:0] waddr_c, wdata_c, raddr_c;

    assign any_req = cpu_req | dma_req;

`ifdef DM_ARB_ROUND_ROBIN_EN
    // High when DMA holds priority for the next tie; it flips to the loser on every grant.
    logic prio_dma_q;

    assign grant_dma = dma_req & (~cpu_req | prio_dma_q);

    always_ff @(posedge clk) begin
        if (Reset) begin
            prio_dma_q <= 1'b0;
        end else if (state_q == S_IDLE && any_req) begin
            prio_dma_q <= ~grant_dma;
        end
    end
`else
    assign grant_dma = dma_req & ~cpu_req;
`endif

    assign addr_err  = |addr_q[31:WORD_BITS+2];
    assign partial   = we_q & (be_q != 4'h0) & (be_q != 4'hF);
    assign byte_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_comb begin
        state_d = state_q;
        we_c    = 1'b0;
        waddr_c = 32'h0;
        wdata_c = 32'h0;
        raddr_c = 32'h0;
        rdata_d = 32'h0;
        err_d   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (addr_err) begin
                    err_d   = 1'b1;
                    finish  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    raddr_c = addr_q;
                    if (!we_q) begin
                        rdata_d = dm_rdata;
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else if (be_q == 4'hF) begin
                        we_c    = 1'b1;
                        waddr_c = addr_q;
                        wdata_c = wdata_q;
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else if (be_q == 4'h0) begin
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                we_c    = 1'b1;
                waddr_c = addr_q;
                wdata_c = (wdata_q & byte_mask) | (merge_q & ~byte_mask);
                finish  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side outputs are gated by reset so an aborted transaction never writes.
    assign dm_we    = we_c & ~Reset;
    assign dm_waddr = Reset ? 32'h0 : waddr_c;
    assign dm_wdata = Reset ? 32'h0 : wdata_c;
    assign dm_raddr = Reset ? 32'h0 : raddr_c;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            id_q        <= ID_CPU;
            cpu_rdata_q <= 32'h0;
            cpu_err_q   <= 1'b0;
            dma_rdata_q <= 32'h0;
            dma_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && any_req) begin
                id_q    <= grant_dma ? ID_DMA : ID_CPU;
                we_q    <= grant_dma ? dma_we    : cpu_we;
                be_q    <= grant_dma ? dma_be    : cpu_be;
                addr_q  <= grant_dma ? dma_addr  : cpu_addr;
                wdata_q <= grant_dma ? dma_wdata : cpu_wdata;
            end
            if (state_q == S_ACCESS && partial && !addr_err) begin
                merge_q <= dm_rdata;
            end
            // Only the winner's result registers move; the other port holds its last result.
            if (finish) begin
                if (id_q == ID_DMA) begin
                    dma_rdata_q <= rdata_d;
                    dma_err_q   <= err_d;
                end else begin
                    cpu_rdata_q <= rdata_d;
                    cpu_err_q   <= err_d;
                end
            end
        end
    end

    assign cpu_ack   = (state_q == S_DONE) && (id_q == ID_CPU) && !Reset;
    assign dma_ack   = (state_q == S_DONE) && (id_q == ID_DMA) && !Reset;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_err   = dma_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dm_access_arbiter                                          |
// | Brief    : Self-checking bench for dm_access_arbiter with a word memory  |
// |            and a transaction-level reference model.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [3:0]  cpu_be, dma_be;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        dm_we;
    logic [31:0] dm_waddr, dm_wdata, dm_raddr, dm_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        mem_clr = 1'b0;
    bit          last_dma;

    always #5 clk = ~clk;

    dm_access_arbiter #(.WORD_BITS(10)) dut (
        .clk(clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata), .dm_raddr(dm_raddr),
        .dm_rdata(dm_rdata)
    );

    assign dm_rdata = mem[dm_raddr[11:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (dm_we) begin
            mem[dm_waddr[11:2]] <= dm_wdata;
        end
    end

    task automatic set_port(input bit is_dma, input bit req, input bit we,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_dma) begin
            dma_req = req; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One transaction from one port, entered in an IDLE cycle; leaves the DUT in IDLE.
    task automatic do_txn(input bit is_dma, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input string name);
        bit          in_range = (addr[31:12] == 20'h0);
        int          idx      = int'(addr[11:2]);
        logic [31:0] exp_rd   = (!we && in_range) ? ref_mem[idx] : 32'h0;
        bit          exp_err  = !in_range;
        int          exp_lat  = (we && in_range && be != 4'h0 && be != 4'hF) ? 3 : 2;
        int          exp_wes  = (we && in_range && be != 4'h0) ? 1 : 0;
        logic [31:0] oth_rd   = is_dma ? cpu_rdata : dma_rdata;
        logic        oth_err  = is_dma ? cpu_err : dma_err;
        int          lat = 0;
        int          wes = 0;
        bit          got = 0;
        logic [31:0] act_rd = 32'h0;
        logic        act_err = 1'b0;

        if (we && in_range) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        set_port(is_dma, 1'b1, we, be, addr, wdata);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (dm_we) wes++;
            tests++;
            if ((is_dma ? cpu_ack : dma_ack) !== 1'b0) begin
                fails++;
                $display("FAIL %s other_ack: got %b want 0", name, is_dma ? cpu_ack : dma_ack);
            end
            if ((is_dma ? dma_ack : cpu_ack) === 1'b1) begin
                got = 1; lat = n;
                act_rd  = is_dma ? dma_rdata : cpu_rdata;
                act_err = is_dma ? dma_err : cpu_err;
                break;
            end
        end
        set_port(is_dma, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tests++;
        if (!got || lat != exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d (acked=%0d) want %0d", name, lat, got, exp_lat);
        end
        tests++;
        if (act_rd !== exp_rd || act_err !== exp_err) begin
            fails++;
            $display("FAIL %s rdata/err: got %h/%b want %h/%b", name, act_rd, act_err, exp_rd, exp_err);
        end
        tests++;
        if (wes != exp_wes) begin
            fails++;
            $display("FAIL %s dm_we_cycles: got %0d want %0d", name, wes, exp_wes);
        end
        tests++;
        if ((is_dma ? cpu_rdata : dma_rdata) !== oth_rd || (is_dma ? cpu_err : dma_err) !== oth_err) begin
            fails++;
            $display("FAIL %s loser_outputs changed: got %h want %h", name,
                     is_dma ? cpu_rdata : dma_rdata, oth_rd);
        end
        @(posedge clk); #1;
        tests++;
        if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
            fails++;
            $display("FAIL %s ack_single_pulse: got cpu=%b dma=%b want 0", name, cpu_ack, dma_ack);
        end
        if (in_range) begin
            tests++;
            if (mem[idx] !== ref_mem[idx]) begin
                fails++;
                $display("FAIL %s mem_word: got %h want %h", name, mem[idx], ref_mem[idx]);
            end
        end
        last_dma = is_dma;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        last_dma = 1'b1;
    endtask

    task automatic test_reset();
        mem_clr = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        apply_reset();
        mem_clr = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({cpu_ack, dma_ack, cpu_err, dma_err, dm_we} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000", {cpu_ack, dma_ack, cpu_err, dma_err, dm_we});
        end
        tests++;
        if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0 || dm_waddr !== 32'h0 ||
            dm_wdata !== 32'h0 || dm_raddr !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h %h %h want 0", cpu_rdata, dma_rdata,
                     dm_waddr, dm_wdata, dm_raddr);
        end
    endtask

    task automatic test_store_load();
        do_txn(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "cpu_store_full");
        do_txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "cpu_load");
        tests++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL store_load_value: got %h want deadbeef", cpu_rdata);
        end
    endtask

    task automatic test_partial_store();
        do_txn(1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, "cpu_store_0x20");
        do_txn(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, "dma_partial");
        do_txn(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, "cpu_load_merged");
        tests++;
        if (cpu_rdata !== 32'h1122AA44) begin
            fails++;
            $display("FAIL merged_value: got %h want 1122aa44", cpu_rdata);
        end
    endtask

    task automatic test_contention();
        bit exp_dma;
        bit who;
        apply_reset();
        set_port(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            bit seen = 0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            exp_dma = !last_dma;
`else
            exp_dma = 1'b0;
`endif
            for (int n = 0; n < 10; n++) begin
                @(posedge clk); #1;
                if (cpu_ack || dma_ack) begin seen = 1; break; end
            end
            who = dma_ack;
            tests++;
            if (!seen || (cpu_ack && dma_ack) || who != exp_dma) begin
                fails++;
                $display("FAIL contention_grant%0d: got cpu=%b dma=%b want dma=%b", k, cpu_ack, dma_ack, exp_dma);
            end
            tests++;
            if ((who ? dma_rdata : cpu_rdata) !== ref_mem[who ? 8 : 4]) begin
                fails++;
                $display("FAIL contention_rdata%0d: got %h want %h", k, who ? dma_rdata : cpu_rdata,
                         ref_mem[who ? 8 : 4]);
            end
            last_dma = who;
        end
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_range_error();
        do_txn(1'b0, 1'b0, 4'h0, 32'h00001000, 32'h0, "cpu_load_oob");
        do_txn(1'b1, 1'b1, 4'hF, 32'h80000010, 32'h12345678, "dma_store_oob");
    endtask

    task automatic test_reset_in_merge();
        do_txn(1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, "cpu_store_0x40");
        set_port(1'b1, 1'b1, 1'b1, 4'b0001, 32'h40, 32'h000000FF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (dm_we !== 1'b1) begin
            fails++;
            $display("FAIL merge_we_before_reset: got %b want 1", dm_we);
        end
        Reset = 1'b1;
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        tests++;
        if (dm_we !== 1'b0) begin
            fails++;
            $display("FAIL merge_we_in_reset: got %b want 0", dm_we);
        end
        @(posedge clk); #1;
        Reset = 1'b0;
        last_dma = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tests++;
            if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || cpu_rdata !== 32'h0) begin
                fails++;
                $display("FAIL abort_no_ack: got cpu=%b dma=%b rdata=%h want 0", cpu_ack, dma_ack, cpu_rdata);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (mem[16] !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL abort_mem: got %h want cafef00d", mem[16]);
        end
        do_txn(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, "load_after_abort");
    endtask

    task automatic test_be_zero();
        do_txn(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "dma_store_be0");
        do_txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "cpu_after_be0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   a, $urandom, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_contention();
        test_range_error();
        test_reset_in_merge();
        test_be_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
